// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS Execute-stage controller: opcodes, ALU op
// codes, the ID/EX control bundle and the hazard sequencer states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] aluOp;
    logic       aluSrc;
    logic       regDst;
    logic       memRead;
    logic       memWrite;
    logic       regWrite;
    logic       memToReg;
    logic       branch;
  } ex_ctrl_t;

  localparam ex_ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode-to-control decode; unknown opcodes yield a bubble
// flagged as illegal.
module main_decoder
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ex_ctrl_t   ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = CTRL_BUBBLE;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.aluOp    = ALUOP_FUNCT;
        ctrl_o.regDst   = 1'b1;
        ctrl_o.regWrite = 1'b1;
      end
      OP_LW: begin
        ctrl_o.aluOp    = ALUOP_ADD;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.memRead  = 1'b1;
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memToReg = 1'b1;
      end
      OP_SW: begin
        ctrl_o.aluOp    = ALUOP_ADD;
        ctrl_o.aluSrc   = 1'b1;
        ctrl_o.memWrite = 1'b1;
      end
      OP_BEQ: begin
        ctrl_o.aluOp  = ALUOP_SUB;
        ctrl_o.branch = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_ctrl.sv
// ID/EX control register with load-use stall, taken-branch flush and
// saturating debug counters for the Execute stage.
module exec_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       idOpcode,
  input  logic [4:0]       idRs,
  input  logic [4:0]       idRt,
  input  logic             exZero,
  output logic [1:0]       aluOp,
  output logic             aluSrc,
  output logic             regDst,
  output logic             memRead,
  output logic             memWrite,
  output logic             regWrite,
  output logic             memToReg,
  output logic             branchEx,
  output logic [4:0]       exRt,
  output logic             stall,
  output logic             flush,
  output logic             pcSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  ex_ctrl_t         dec_ctrl, ctrl_q, ctrl_d;
  logic             dec_illegal, illegal_q, illegal_d;
  logic [4:0]       exRt_q, exRt_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d, flushCnt_q, flushCnt_d;
  logic             usesRt, hz, brTaken;

  main_decoder u_dec (
    .opcode_i  (idOpcode),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  // rt is only a source operand for R-type, sw and beq.
  always_comb begin
    usesRt  = (idOpcode == OP_RTYPE) || (idOpcode == OP_SW) || (idOpcode == OP_BEQ);
    hz      = ctrl_q.memRead && (exRt_q != '0) &&
              ((exRt_q == idRs) || ((exRt_q == idRt) && usesRt));
    brTaken = ctrl_q.branch && exZero;
  end

  assign stall = reset && hz && !brTaken;
  assign flush = reset && brTaken;
  assign pcSrc = reset && brTaken;

  always_comb begin
    state_d    = RUN;
    ctrl_d     = dec_ctrl;
    exRt_d     = idRt;
    illegal_d  = dec_illegal;
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (brTaken) begin
      state_d   = FLUSH;
      ctrl_d    = CTRL_BUBBLE;
      exRt_d    = '0;
      illegal_d = 1'b0;
      if (state_q != FLUSH) flushCnt_d = sat_inc(flushCnt_q);
    end else if (hz) begin
      state_d   = STALL;
      ctrl_d    = CTRL_BUBBLE;
      exRt_d    = '0;
      illegal_d = 1'b0;
      if (state_q != STALL) stallCnt_d = sat_inc(stallCnt_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= RUN;
      ctrl_q     <= CTRL_BUBBLE;
      exRt_q     <= '0;
      illegal_q  <= 1'b0;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      exRt_q     <= exRt_d;
      illegal_q  <= illegal_d;
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign aluOp    = ctrl_q.aluOp;
  assign aluSrc   = ctrl_q.aluSrc;
  assign regDst   = ctrl_q.regDst;
  assign memRead  = ctrl_q.memRead;
  assign memWrite = ctrl_q.memWrite;
  assign regWrite = ctrl_q.regWrite;
  assign memToReg = ctrl_q.memToReg;
  assign branchEx = ctrl_q.branch;
  assign exRt     = exRt_q;
  assign illegal  = illegal_q;
  assign stallCnt = stallCnt_q;
  assign flushCnt = flushCnt_q;

endmodule
